axi_mux2: RTL and testbench

AXI_MUX2 -- requirements
Module: axi_mux2

---
 rtl/axi_mux2_pkg.sv | 65 ++++++
 rtl/axi_mux2_dir_arb.sv | 95 +++++++++
 rtl/axi_mux2.sv | 97 +++++++++
 tb/tb_axi_mux2.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_mux2_pkg.sv
// Shared types for the two-requester AXI multiplexer: channel payloads,
// request/response bundles, arbitration state and counter sizing.
package axi_mux2_pkg;

  localparam int unsigned IdW   = 4;
  localparam int unsigned AddrW = 16;
  localparam int unsigned DataW = 32;
  localparam int unsigned LenW  = 8;
  localparam int unsigned RespW = 2;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [AddrW-1:0] addr;
    logic [LenW-1:0]  len;
  } ax_chan_t;

  typedef struct packed {
    logic [DataW-1:0] data;
    logic             last;
  } w_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [RespW-1:0] resp;
  } b_chan_t;

  typedef struct packed {
    logic [IdW-1:0]   id;
    logic [DataW-1:0] data;
    logic [RespW-1:0] resp;
    logic             last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } mux_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    b_chan_t b;
    logic    b_valid;
    r_chan_t r;
    logic    r_valid;
  } mux_resp_t;

  // Outstanding counter must hold 0..max_trans inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_trans);
    return $clog2(max_trans + 1);
  endfunction

endpackage

// File: rtl/axi_mux2_dir_arb.sv
// Per-direction arbiter: picks an owner, holds it while transactions are
// outstanding or an address beat is pending, and caps outstanding count.
module axi_mux2_dir_arb
  import axi_mux2_pkg::*;
#(
  parameter int unsigned MaxTrans = 32'd4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_valid,
  input  logic       mst_ready,
  input  logic       done,
  output logic       sel_c,
  output logic       mst_valid_c,
  output logic [1:0] req_ready_c,
  output logic       owner,
  output logic       busy
);

  localparam int unsigned CntW = cnt_width(MaxTrans);

  arb_state_e      state, state_d;
  logic            owner_d;
  logic            prio, prio_d;
  logic            lock, lock_d;
  logic [CntW-1:0] cnt, cnt_d;
  logic            full;
  logic            hs;
  logic            dec;

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state <= IDLE;
      owner <= 1'b0;
      prio  <= 1'b0;
      lock  <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      owner <= owner_d;
      prio  <= prio_d;
      lock  <= lock_d;
      cnt   <= cnt_d;
    end
  end

  // Selection, handshake and next-state logic
  always_comb begin
    state_d     = state;
    owner_d     = owner;
    prio_d      = prio;
    lock_d      = lock;
    cnt_d       = cnt;
    sel_c       = owner;
    mst_valid_c = 1'b0;
    req_ready_c = 2'b00;
    hs          = 1'b0;
    dec         = 1'b0;
    full        = (cnt == CntW'(MaxTrans));

    if (state == IDLE) begin
      if (req_valid[0] && req_valid[1]) begin
        sel_c = prio;
      end else begin
        sel_c = req_valid[1];
      end
      if (req_valid != 2'b00) begin
        owner_d = sel_c;
      end
    end

    mst_valid_c        = req_valid[sel_c] & ~full;
    hs                 = mst_valid_c & mst_ready;
    req_ready_c[sel_c] = hs;

    // A presented but unaccepted beat pins the owner until it is taken.
    lock_d = mst_valid_c & ~mst_ready;
    if (hs) begin
      prio_d = ~sel_c;
    end

    dec = done & (cnt != '0);
    if (hs && !dec) begin
      cnt_d = cnt + CntW'(1);
    end else if (dec && !hs) begin
      cnt_d = cnt - CntW'(1);
    end

    state_d = ((cnt_d != '0) || lock_d) ? BUSY : IDLE;
  end

  assign busy = (state == BUSY);

endmodule

// File: rtl/axi_mux2.sv
// Two-to-one AXI multiplexer with independent write/read arbitration and
// zero-latency combinational forwarding between requesters and master.
module axi_mux2
  import axi_mux2_pkg::*;
#(
  parameter int unsigned MaxTrans   = 32'd4,
  parameter type         axi_req_t  = mux_req_t,
  parameter type         axi_resp_t = mux_resp_t
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  axi_req_t  slv0_req_i,
  output axi_resp_t slv0_resp_o,
  input  axi_req_t  slv1_req_i,
  output axi_resp_t slv1_resp_o,
  output axi_req_t  mst_req_o,
  input  axi_resp_t mst_resp_i
);

  logic       wr_sel_c, wr_mst_valid_c, wr_owner, wr_busy;
  logic [1:0] wr_ready_c;
  logic       rd_sel_c, rd_mst_valid_c, rd_owner, rd_busy;
  logic [1:0] rd_ready_c;
  logic       b_ready_c, b_done_c;
  logic       r_ready_c, r_done_c;

  // Response-side ready comes from the current owner only.
  assign b_ready_c = wr_busy & (wr_owner ? slv1_req_i.b_ready : slv0_req_i.b_ready);
  assign b_done_c  = mst_resp_i.b_valid & b_ready_c;
  assign r_ready_c = rd_busy & (rd_owner ? slv1_req_i.r_ready : slv0_req_i.r_ready);
  assign r_done_c  = mst_resp_i.r_valid & r_ready_c & mst_resp_i.r.last;

  axi_mux2_dir_arb #(
    .MaxTrans (MaxTrans)
  ) u_wr_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid   ({slv1_req_i.aw_valid, slv0_req_i.aw_valid}),
    .mst_ready   (mst_resp_i.aw_ready),
    .done        (b_done_c),
    .sel_c       (wr_sel_c),
    .mst_valid_c (wr_mst_valid_c),
    .req_ready_c (wr_ready_c),
    .owner       (wr_owner),
    .busy        (wr_busy)
  );

  axi_mux2_dir_arb #(
    .MaxTrans (MaxTrans)
  ) u_rd_arb (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid   ({slv1_req_i.ar_valid, slv0_req_i.ar_valid}),
    .mst_ready   (mst_resp_i.ar_ready),
    .done        (r_done_c),
    .sel_c       (rd_sel_c),
    .mst_valid_c (rd_mst_valid_c),
    .req_ready_c (rd_ready_c),
    .owner       (rd_owner),
    .busy        (rd_busy)
  );

  // Channel routing
  always_comb begin
    mst_req_o   = '0;
    slv0_resp_o = '0;
    slv1_resp_o = '0;

    mst_req_o.aw         = wr_sel_c ? slv1_req_i.aw : slv0_req_i.aw;
    mst_req_o.aw_valid   = wr_mst_valid_c;
    slv0_resp_o.aw_ready = wr_ready_c[0];
    slv1_resp_o.aw_ready = wr_ready_c[1];

    mst_req_o.w         = wr_owner ? slv1_req_i.w : slv0_req_i.w;
    mst_req_o.w_valid   = wr_busy & (wr_owner ? slv1_req_i.w_valid : slv0_req_i.w_valid);
    slv0_resp_o.w_ready = wr_busy & ~wr_owner & mst_resp_i.w_ready;
    slv1_resp_o.w_ready = wr_busy &  wr_owner & mst_resp_i.w_ready;

    slv0_resp_o.b       = mst_resp_i.b;
    slv1_resp_o.b       = mst_resp_i.b;
    slv0_resp_o.b_valid = wr_busy & ~wr_owner & mst_resp_i.b_valid;
    slv1_resp_o.b_valid = wr_busy &  wr_owner & mst_resp_i.b_valid;
    mst_req_o.b_ready   = b_ready_c;

    mst_req_o.ar         = rd_sel_c ? slv1_req_i.ar : slv0_req_i.ar;
    mst_req_o.ar_valid   = rd_mst_valid_c;
    slv0_resp_o.ar_ready = rd_ready_c[0];
    slv1_resp_o.ar_ready = rd_ready_c[1];

    slv0_resp_o.r       = mst_resp_i.r;
    slv1_resp_o.r       = mst_resp_i.r;
    slv0_resp_o.r_valid = rd_busy & ~rd_owner & mst_resp_i.r_valid;
    slv1_resp_o.r_valid = rd_busy &  rd_owner & mst_resp_i.r_valid;
    mst_req_o.r_ready   = r_ready_c;
  end

endmodule

// File: tb/tb_axi_mux2.sv
// Directed and randomized checks of axi_mux2 with MaxTrans=2; the random
// read phase is scored against a small transaction-level model.
module tb_axi_mux2;
  import axi_mux2_pkg::*;

  localparam int unsigned MT = 2;

  logic      clk;
  logic      rst_n;
  mux_req_t  req0, req1, mreq;
  mux_resp_t resp0, resp1, mresp;

  int unsigned checks = 0;
  int unsigned errors = 0;

  axi_mux2 #(
    .MaxTrans   (MT),
    .axi_req_t  (mux_req_t),
    .axi_resp_t (mux_resp_t)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .slv0_req_i  (req0),
    .slv0_resp_o (resp0),
    .slv1_req_i  (req1),
    .slv1_resp_o (resp1),
    .mst_req_o   (mreq),
    .mst_resp_i  (mresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] quiet_vec();
    return {mreq.aw_valid, mreq.w_valid, mreq.ar_valid, mreq.b_ready, mreq.r_ready,
            resp0.aw_ready, resp0.w_ready, resp0.ar_ready, resp0.b_valid, resp0.r_valid,
            resp1.aw_ready, resp1.w_ready, resp1.ar_ready, resp1.b_valid, resp1.r_valid,
            1'b0};
  endfunction

  // model state for the random read phase
  bit [1:0]    mv;
  logic [15:0] maddr [2];
  int          m_out, m_owner, m_prio, pick;
  bit          m_stuck, idle, fwd, hs, rv, rlast, rr0, rr1, rdone;

  initial begin
    rst_n = 1'b0;
    req0  = '0;
    req1  = '0;
    mresp = '0;
    mresp.aw_ready = 1'b1;
    mresp.ar_ready = 1'b1;
    mresp.w_ready  = 1'b1;
    repeat (3) tick();
    chk("reset_quiet", 64'(quiet_vec()), 64'd0);
    chk("reset_wr_cnt", 64'(dut.u_wr_arb.cnt), 64'd0);
    chk("reset_rd_cnt", 64'(dut.u_rd_arb.cnt), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_quiet", 64'(quiet_vec()), 64'd0);

    // simultaneous AW: slv0 first, slv1 after slv0's B
    req0.aw_valid = 1'b1; req0.aw.addr = 16'h0100;
    req1.aw_valid = 1'b1; req1.aw.addr = 16'h0200;
    #1;
    chk("sim_aw_valid", 64'(mreq.aw_valid), 64'd1);
    chk("sim_aw_addr", 64'(mreq.aw.addr), 64'h100);
    chk("sim_aw_ready0", 64'(resp0.aw_ready), 64'd1);
    chk("sim_aw_ready1", 64'(resp1.aw_ready), 64'd0);
    tick();
    req0.aw_valid = 1'b0;
    #1;
    chk("busy_block_valid", 64'(mreq.aw_valid), 64'd0);
    chk("busy_block_ready1", 64'(resp1.aw_ready), 64'd0);
    chk("busy_wr_cnt", 64'(dut.u_wr_arb.cnt), 64'd1);
    tick();
    mresp.b_valid = 1'b1; mresp.b.id = 4'h5; req0.b_ready = 1'b1;
    #1;
    chk("b_valid0", 64'(resp0.b_valid), 64'd1);
    chk("b_valid1_gated", 64'(resp1.b_valid), 64'd0);
    chk("b_bcast_id", 64'(resp1.b.id), 64'h5);
    chk("b_ready_mst", 64'(mreq.b_ready), 64'd1);
    tick();
    mresp.b_valid = 1'b0; req0.b_ready = 1'b0;
    #1;
    chk("second_aw_valid", 64'(mreq.aw_valid), 64'd1);
    chk("second_aw_addr", 64'(mreq.aw.addr), 64'h200);
    chk("second_aw_ready1", 64'(resp1.aw_ready), 64'd1);
    tick();
    req1.aw_valid = 1'b0;
    mresp.b_valid = 1'b1; req1.b_ready = 1'b1;
    #1;
    chk("b1_valid1", 64'(resp1.b_valid), 64'd1);
    chk("b1_valid0_gated", 64'(resp0.b_valid), 64'd0);
    tick();
    mresp.b_valid = 1'b0; req1.b_ready = 1'b0;

    // master stalls AW for 5 cycles; slv0 joins but must not steal
    mresp.aw_ready = 1'b0;
    req1.aw_valid = 1'b1; req1.aw.addr = 16'h0300;
    for (int k = 0; k < 5; k++) begin
      if (k == 1) begin
        req0.aw_valid = 1'b1; req0.aw.addr = 16'h0400;
      end
      #1;
      chk("stall_aw_valid", 64'(mreq.aw_valid), 64'd1);
      chk("stall_aw_addr", 64'(mreq.aw.addr), 64'h300);
      chk("stall_ready0", 64'(resp0.aw_ready), 64'd0);
      tick();
      chk("stall_owner", 64'(dut.u_wr_arb.owner), 64'd1);
    end
    mresp.aw_ready = 1'b1;
    #1;
    chk("stall_release1", 64'(resp1.aw_ready), 64'd1);
    chk("stall_release0", 64'(resp0.aw_ready), 64'd0);
    tick();
    req1.aw_valid = 1'b0;
    mresp.b_valid = 1'b1; req1.b_ready = 1'b1;
    #1;
    chk("owner1_blocks_slv0", 64'(mreq.aw_valid), 64'd0);
    tick();
    mresp.b_valid = 1'b0; req1.b_ready = 1'b0;
    #1;
    chk("slv0_grant_addr", 64'(mreq.aw.addr), 64'h400);
    chk("slv0_grant_ready", 64'(resp0.aw_ready), 64'd1);
    tick();

    // B and AW handshakes in the same cycle with one outstanding
    req0.aw.addr = 16'h0500;
    mresp.b_valid = 1'b1; req0.b_ready = 1'b1;
    #1;
    chk("same_cyc_aw_ready", 64'(resp0.aw_ready), 64'd1);
    chk("same_cyc_b_valid", 64'(resp0.b_valid), 64'd1);
    tick();
    chk("same_cyc_cnt", 64'(dut.u_wr_arb.cnt), 64'd1);
    chk("same_cyc_owner", 64'(dut.u_wr_arb.owner), 64'd0);
    req0.aw_valid = 1'b0;
    tick();
    mresp.b_valid = 1'b0; req0.b_ready = 1'b0;
    chk("drain_cnt", 64'(dut.u_wr_arb.cnt), 64'd0);
    chk("drain_idle", 64'(dut.u_wr_arb.busy), 64'd0);

    // W offered in write IDLE is held off until AW is granted
    req1.w_valid = 1'b1; req1.w.data = 32'hA0; req1.w.last = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("w_idle_ready1", 64'(resp1.w_ready), 64'd0);
      chk("w_idle_mvalid", 64'(mreq.w_valid), 64'd0);
      tick();
    end
    req1.aw_valid = 1'b1; req1.aw.addr = 16'h0600; req1.aw.len = 8'd3;
    #1;
    chk("w_aw_grant", 64'(resp1.aw_ready), 64'd1);
    chk("w_grant_cycle_ready", 64'(resp1.w_ready), 64'd0);
    tick();
    req1.aw_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req1.w.data = 32'hA0 + 32'(i);
      req1.w.last = (i == 3);
      #1;
      chk("w_beat_valid", 64'(mreq.w_valid), 64'd1);
      chk("w_beat_data", 64'(mreq.w.data), 64'(32'hA0 + 32'(i)));
      chk("w_beat_last", 64'(mreq.w.last), 64'(i == 3));
      chk("w_beat_ready1", 64'(resp1.w_ready), 64'd1);
      chk("w_beat_ready0", 64'(resp0.w_ready), 64'd0);
      tick();
    end
    req1.w_valid = 1'b0;
    mresp.b_valid = 1'b1; req1.b_ready = 1'b1;
    tick();
    mresp.b_valid = 1'b0; req1.b_ready = 1'b0;

    // outstanding limit on reads (MaxTrans=2)
    req0.ar_valid = 1'b1; req0.ar.addr = 16'h1000;
    #1;
    chk("ar0_ready", 64'(resp0.ar_ready), 64'd1);
    tick();
    req0.ar.addr = 16'h1001;
    #1;
    chk("ar1_ready", 64'(resp0.ar_ready), 64'd1);
    tick();
    req0.ar.addr = 16'h1002;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("ar_full_valid", 64'(mreq.ar_valid), 64'd0);
      chk("ar_full_ready", 64'(resp0.ar_ready), 64'd0);
      tick();
    end
    mresp.r_valid = 1'b1; mresp.r.last = 1'b0; req0.r_ready = 1'b1;
    #1;
    chk("r_nonlast_valid0", 64'(resp0.r_valid), 64'd1);
    chk("r_nonlast_valid1", 64'(resp1.r_valid), 64'd0);
    chk("r_nonlast_block", 64'(resp0.ar_ready), 64'd0);
    tick();
    mresp.r.last = 1'b1;
    #1;
    chk("r_last_block", 64'(resp0.ar_ready), 64'd0);
    chk("r_last_valid0", 64'(resp0.r_valid), 64'd1);
    tick();
    mresp.r_valid = 1'b0;
    #1;
    chk("ar_unblock_ready", 64'(resp0.ar_ready), 64'd1);
    chk("ar_unblock_addr", 64'(mreq.ar.addr), 64'h1002);
    tick();
    req0.ar_valid = 1'b0;

    // reset with two reads outstanding
    rst_n = 1'b0;
    req0 = '0;
    req1 = '0;
    tick();
    chk("rst_mid_rd_cnt", 64'(dut.u_rd_arb.cnt), 64'd0);
    chk("rst_mid_wr_cnt", 64'(dut.u_wr_arb.cnt), 64'd0);
    chk("rst_mid_quiet", 64'(quiet_vec()), 64'd0);
    rst_n = 1'b1;
    tick();
    req0.ar_valid = 1'b1; req0.ar.addr = 16'h2000;
    req1.ar_valid = 1'b1; req1.ar.addr = 16'h3000;
    #1;
    chk("post_rst_addr", 64'(mreq.ar.addr), 64'h2000);
    chk("post_rst_ready0", 64'(resp0.ar_ready), 64'd1);
    chk("post_rst_ready1", 64'(resp1.ar_ready), 64'd0);
    tick();

    // randomized read traffic against the model
    rst_n = 1'b0;
    req0 = '0;
    req1 = '0;
    mresp = '0;
    tick();
    rst_n = 1'b1;
    tick();
    mv = 2'b00; m_out = 0; m_owner = 0; m_prio = 0; m_stuck = 1'b0;
    maddr[0] = '0; maddr[1] = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        if (!mv[i] && $urandom_range(0, 2) == 0) begin
          mv[i] = 1'b1;
          maddr[i] = 16'($urandom);
        end
      end
      req0.ar_valid = mv[0]; req0.ar.addr = maddr[0];
      req1.ar_valid = mv[1]; req1.ar.addr = maddr[1];
      mresp.ar_ready = 1'($urandom_range(0, 1));
      rv    = (m_out > 0) && ($urandom_range(0, 1) == 1);
      rlast = 1'($urandom_range(0, 1));
      rr0   = 1'($urandom_range(0, 1));
      rr1   = 1'($urandom_range(0, 1));
      mresp.r_valid = rv; mresp.r.last = rlast; mresp.r.data = $urandom;
      req0.r_ready = rr0; req1.r_ready = rr1;
      #1;
      idle = (m_out == 0) && !m_stuck;
      if (idle) pick = (mv[0] && mv[1]) ? m_prio : (mv[1] ? 1 : 0);
      else pick = m_owner;
      fwd = mv[pick] && (m_out < int'(MT));
      hs  = fwd && mresp.ar_ready;
      chk("rnd_ar_valid", 64'(mreq.ar_valid), 64'(fwd));
      if (fwd) chk("rnd_ar_addr", 64'(mreq.ar.addr), 64'(maddr[pick]));
      chk("rnd_ar_ready0", 64'(resp0.ar_ready), 64'(hs && pick == 0));
      chk("rnd_ar_ready1", 64'(resp1.ar_ready), 64'(hs && pick == 1));
      chk("rnd_r_valid0", 64'(resp0.r_valid), 64'(rv && m_owner == 0));
      chk("rnd_r_valid1", 64'(resp1.r_valid), 64'(rv && m_owner == 1));
      rdone = rv && rlast && ((m_owner == 0) ? rr0 : rr1);
      if (idle && (mv != 2'b00)) m_owner = pick;
      if (hs) begin
        mv[pick] = 1'b0;
        m_prio = 1 - pick;
      end
      m_out = m_out + (hs ? 1 : 0) - (rdone ? 1 : 0);
      m_stuck = fwd && !hs;
      tick();
      chk("rnd_rd_cnt", 64'(dut.u_rd_arb.cnt), 64'(m_out));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
